// File: rtl/cam_match_if.sv
// cam_match_if: update, lookup-request and lookup-result handshakes of the CAM match engine
interface cam_match_if #(
    parameter int KEY_SIZE          = 8,
    parameter int VALUE_SIZE        = 32,
    parameter int UPDATE_USER_WIDTH = 4,
    parameter int LOOKUP_USER_WIDTH = 4
);
    logic [KEY_SIZE-1:0]          update_req_index;
    logic [VALUE_SIZE-1:0]        update_req_data;
    logic                         update_req_valid;
    logic                         update_req_ready;
    logic [UPDATE_USER_WIDTH-1:0] update_req_user;
    logic [KEY_SIZE-1:0]          lookup_req_index;
    logic                         lookup_req_valid;
    logic                         lookup_req_ready;
    logic [LOOKUP_USER_WIDTH-1:0] lookup_req_user;
    logic [VALUE_SIZE-1:0]        lookup_value_data;
    logic                         lookup_value_hit;
    logic                         lookup_value_valid;
    logic                         lookup_value_ready;
    logic [LOOKUP_USER_WIDTH-1:0] lookup_value_user;

    modport master (
        output update_req_index, update_req_data, update_req_valid, update_req_user,
        input  update_req_ready,
        output lookup_req_index, lookup_req_valid, lookup_req_user,
        input  lookup_req_ready,
        input  lookup_value_data, lookup_value_hit, lookup_value_valid, lookup_value_user,
        output lookup_value_ready
    );

    modport slave (
        input  update_req_index, update_req_data, update_req_valid, update_req_user,
        output update_req_ready,
        input  lookup_req_index, lookup_req_valid, lookup_req_user,
        output lookup_req_ready,
        output lookup_value_data, lookup_value_hit, lookup_value_valid, lookup_value_user,
        input  lookup_value_ready
    );
endinterface

// File: rtl/cam_match_engine.sv
// cam_match_engine: flop-based key/value table with single-cycle updates and a 2-stage lookup pipeline
module cam_match_engine #(
    parameter int TABLE_SIZE        = 16,
    parameter int KEY_SIZE          = 8,
    parameter int VALUE_SIZE        = 32,
    parameter int UPDATE_USER_WIDTH = 4,
    parameter int LOOKUP_USER_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    cam_match_if.slave                        bus,
    output logic [$clog2(TABLE_SIZE+1)-1:0]   entry_count,
    output logic                              update_evict
);
    localparam int IW = $clog2(TABLE_SIZE);

    logic [TABLE_SIZE-1:0]        ent_valid;
    logic [KEY_SIZE-1:0]          ent_key [TABLE_SIZE];
    logic [VALUE_SIZE-1:0]        ent_val [TABLE_SIZE];
    logic [IW-1:0]                victim_ptr;
    logic [IW-1:0]                upd_idx;
    logic [IW-1:0]                free_idx;
    logic [IW-1:0]                sel_idx;
    logic                         upd_match;
    logic                         has_free;
    logic                         upd_ready;
    logic                         upd_fire;
    logic                         lk_hit;
    logic [VALUE_SIZE-1:0]        lk_data;
    logic                         lk_fire;
    logic                         stall;
    logic                         a_valid;
    logic [KEY_SIZE-1:0]          a_key;
    logic [LOOKUP_USER_WIDTH-1:0] a_user;
    logic                         out_valid;
    logic                         out_hit;
    logic [VALUE_SIZE-1:0]        out_data;
    logic [LOOKUP_USER_WIDTH-1:0] out_user;
    logic                         unused_update_user;

    assign unused_update_user = ^bus.update_req_user;

    // Descending scan so the lowest matching/free index wins
    always_comb begin
        upd_match = 1'b0;
        upd_idx   = '0;
        has_free  = 1'b0;
        free_idx  = '0;
        lk_hit    = 1'b0;
        lk_data   = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
            if (ent_valid[i] && ent_key[i] == bus.update_req_index) begin
                upd_match = 1'b1;
                upd_idx   = IW'(i);
            end
            if (ent_valid[i] && ent_key[i] == a_key) begin
                lk_hit  = 1'b1;
                lk_data = ent_val[i];
            end
        end
    end

    assign sel_idx  = upd_match ? upd_idx : has_free ? free_idx : victim_ptr;
    assign upd_fire = bus.update_req_valid && upd_ready;
    assign stall    = out_valid && !bus.lookup_value_ready;
    assign lk_fire  = bus.lookup_req_valid && bus.lookup_req_ready;

    assign bus.update_req_ready   = upd_ready;
    assign bus.lookup_req_ready   = !rst && !(a_valid && stall);
    assign bus.lookup_value_valid = out_valid;
    assign bus.lookup_value_hit   = out_hit;
    assign bus.lookup_value_data  = out_data;
    assign bus.lookup_value_user  = out_user;

    always_ff @(posedge clk) begin
        if (upd_fire) begin
            ent_key[sel_idx] <= bus.update_req_index;
            ent_val[sel_idx] <= bus.update_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid    <= '0;
            victim_ptr   <= '0;
            entry_count  <= '0;
            update_evict <= 1'b0;
            upd_ready    <= 1'b0;
        end else begin
            upd_ready    <= 1'b1;
            update_evict <= upd_fire && !upd_match && !has_free;
            if (upd_fire) begin
                ent_valid[sel_idx] <= 1'b1;
                if (!upd_match && has_free)
                    entry_count <= entry_count + 1'b1;
                if (!upd_match && !has_free)
                    victim_ptr <= victim_ptr + 1'b1;
            end
        end
    end

    // The compare runs as A advances, so a lookup held in A sees updates made while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_key     <= '0;
            a_user    <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
        end else begin
            if (!stall) begin
                out_valid <= a_valid;
                out_hit   <= a_valid && lk_hit;
                out_data  <= a_valid ? lk_data : '0;
                out_user  <= a_valid ? a_user : '0;
            end
            if (lk_fire) begin
                a_valid <= 1'b1;
                a_key   <= bus.lookup_req_index;
                a_user  <= bus.lookup_req_user;
            end else if (!stall) begin
                a_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cam_match_engine.sv
// tb_cam_match_engine: directed stimulus with a response scoreboard checked by a separate monitor
module tb_cam_match_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] entry_count;
    logic       update_evict;

    typedef struct packed {
        logic [31:0] d;
        logic        h;
        logic [3:0]  u;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cam_match_if #(.KEY_SIZE(8), .VALUE_SIZE(32), .UPDATE_USER_WIDTH(4), .LOOKUP_USER_WIDTH(4)) bus ();

    cam_match_engine dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .entry_count  (entry_count),
        .update_evict (update_evict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] val(input logic [7:0] k);
        return 32'hA000_0000 | {24'h0, k};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: one pop per accepted result
    always @(negedge clk) begin
        if (!rst && bus.lookup_value_valid && bus.lookup_value_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got user %0d data 0x%0h, expected none",
                         bus.lookup_value_user, bus.lookup_value_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", bus.lookup_value_data, e.d);
                chk("resp_hit", bus.lookup_value_hit, e.h);
                chk("resp_user", bus.lookup_value_user, e.u);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_update_ready", bus.update_req_ready, 0);
        chk("rst_lookup_ready", bus.lookup_req_ready, 0);
        chk("rst_value_valid", bus.lookup_value_valid, 0);
        chk("rst_entry_count", entry_count, 0);
        chk("rst_evict", update_evict, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_update_ready", bus.update_req_ready, 1);
        chk("post_rst_lookup_ready", bus.lookup_req_ready, 1);
    endtask

    task automatic do_update(input logic [7:0] k, input logic [31:0] d, input logic ev, input int cnt);
        bus.update_req_valid = 1'b1;
        bus.update_req_index = k;
        bus.update_req_data  = d;
        bus.update_req_user  = k[3:0];
        @(posedge clk);
        #1;
        bus.update_req_valid = 1'b0;
        chk("update_evict", update_evict, ev);
        chk("entry_count", entry_count, cnt);
    endtask

    task automatic send_lookup(input logic [7:0] k, input logic [3:0] ku, input logic [31:0] kd,
                               input logic kh, input bit keep);
        bit done = 1'b0;
        bus.lookup_req_valid = 1'b1;
        bus.lookup_req_index = k;
        bus.lookup_req_user  = ku;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.lookup_req_ready) begin
                if (keep) sb.push_back('{d: kd, h: kh, u: ku});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.lookup_req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lookup_accept_timeout: key 0x%0h never accepted, expected acceptance", k);
        end
    endtask

    initial begin
        bus.update_req_valid   = 1'b0;
        bus.update_req_index   = '0;
        bus.update_req_data    = '0;
        bus.update_req_user    = '0;
        bus.lookup_req_valid   = 1'b0;
        bus.lookup_req_index   = '0;
        bus.lookup_req_user    = '0;
        bus.lookup_value_ready = 1'b1;
        do_reset();

        send_lookup(8'h05, 4'd1, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("latency_valid", bus.lookup_value_valid, 1);
        chk("empty_count", entry_count, 0);
        do_update(8'h05, 32'hDEAD_BEEF, 1'b0, 1);
        send_lookup(8'h05, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b1);
        do_update(8'h05, 32'h0000_1234, 1'b0, 1);
        send_lookup(8'h05, 4'd2, 32'h0000_1234, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        do_reset();
        for (int k = 0; k < 16; k++) do_update(8'(8'h10 + k), val(8'(8'h10 + k)), 1'b0, k + 1);
        do_update(8'h20, val(8'h20), 1'b1, 16);
        do_update(8'h21, val(8'h21), 1'b1, 16);
        send_lookup(8'h10, 4'd4, 32'h0, 1'b0, 1'b1);
        send_lookup(8'h11, 4'd5, 32'h0, 1'b0, 1'b1);
        send_lookup(8'h20, 4'd6, val(8'h20), 1'b1, 1'b1);
        send_lookup(8'h21, 4'd7, val(8'h21), 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: first result held in output, second held in A, third refused
        bus.lookup_value_ready = 1'b0;
        fork
            begin
                send_lookup(8'h12, 4'd4, val(8'h12), 1'b1, 1'b1);
                send_lookup(8'h13, 4'd5, 32'hCAFE_0013, 1'b1, 1'b1);
                send_lookup(8'h14, 4'd6, val(8'h14), 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_accepted", sb.size(), 2);
                chk("stall_req_ready", bus.lookup_req_ready, 0);
                chk("stall_valid", bus.lookup_value_valid, 1);
                chk("stall_data", bus.lookup_value_data, val(8'h12));
                chk("stall_user", bus.lookup_value_user, 4);
                do_update(8'h13, 32'hCAFE_0013, 1'b0, 16);
                chk("hold_valid", bus.lookup_value_valid, 1);
                chk("hold_data", bus.lookup_value_data, val(8'h12));
                chk("hold_hit", bus.lookup_value_hit, 1);
                chk("hold_user", bus.lookup_value_user, 4);
                @(posedge clk);
                #1;
                bus.lookup_value_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Update accepted at the edge where the lookup leaves A is not visible to it
        fork
            send_lookup(8'h30, 4'd8, 32'h0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                #1;
                do_update(8'h30, val(8'h30), 1'b1, 16);
            end
        join
        send_lookup(8'h30, 4'd9, val(8'h30), 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        send_lookup(8'h21, 4'd10, val(8'h21), 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_count", entry_count, 0);
        chk("midrst_valid", bus.lookup_value_valid, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_resp", bus.lookup_value_valid, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_match_engine.md
Name: cam_match_engine

Overview:
- Key/value match table that consumes the single arbitrated update stream and the single arbitrated lookup stream produced by the CAM arbitration stage.
- Lookup results carry the requester's user tag back upstream for demultiplexing.
- Holds TABLE_SIZE entries in flops, each a {valid, key, value} tuple.
- Updates are single-cycle; lookups use a 2-stage pipeline with output backpressure.

Parameters:
- TABLE_SIZE, 16, number of entries (power of two, >=2)
- KEY_SIZE, 8, key width
- VALUE_SIZE, 32, value width
- UPDATE_USER_WIDTH, 4, update tag width
- LOOKUP_USER_WIDTH, 4, lookup tag width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- update_req_index  in  KEY_SIZE  key to insert or overwrite
- update_req_data  in  VALUE_SIZE  value to store
- update_req_valid  in  1  update request valid
- update_req_ready  out  1  update accept
- update_req_user  in  UPDATE_USER_WIDTH  source tag; not stored
- lookup_req_index  in  KEY_SIZE  key to search
- lookup_req_valid  in  1  lookup request valid
- lookup_req_ready  out  1  lookup accept
- lookup_req_user  in  LOOKUP_USER_WIDTH  requester tag
- lookup_value_data  out  VALUE_SIZE  matched value; 0 on miss
- lookup_value_hit  out  1  1 = key found
- lookup_value_valid  out  1  result valid
- lookup_value_ready  in  1  result accept
- lookup_value_user  out  LOOKUP_USER_WIDTH  tag echoed from the request
- entry_count  out  $clog2(TABLE_SIZE+1)  number of valid entries
- update_evict  out  1  one-cycle pulse when an update displaced a live entry

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - Clears all valid bits and the victim pointer (to 0).
  - Empties both lookup stages.
  - Forces every output to 0: update_req_ready, lookup_value_*, entry_count, update_evict.
  - lookup_req_ready = 0 while rst=1.
  - A request in flight is dropped with no response.
  - update_req_ready is a register: 0 during reset, 1 from the first edge after rst deasserts, and constant 1 thereafter.
- Update (accepted when valid && ready), applied at that edge. Entry selection:
  1. If a valid entry has the same key, overwrite its value; entry_count unchanged.
  2. Else write the lowest-index invalid entry, set its valid bit, and increment entry_count.
  3. Else (table full) overwrite entry[victim_ptr], pulse update_evict for the next cycle, and set victim_ptr = (victim_ptr+1) mod TABLE_SIZE.
- Keys are unique by construction, so at most one entry matches.
- Lookup pipeline:
  - Stage A holds {key, user, a_valid}; the output register holds {data, hit, user, valid}.
  - stall = lookup_value_valid && !lookup_value_ready.
  - lookup_req_ready = !rst && !(a_valid && stall).
  - When !stall: A moves to the output register and the compare happens at that edge. A new request loads into A in the same cycle.
  - Compare sees the table as of before the same-edge update. A same-key update accepted in the same cycle is therefore not visible; updates at earlier edges are.
  - A stalled lookup in A re-evaluates when it advances, so it reflects updates made during the stall.
  - Latency: request accepted at edge N gives lookup_value_valid=1 after edge N+1 when no stall. Throughput is 1 per cycle.
- Output hold: while stall, data/hit/user/valid hold stable. lookup_value_valid drops after the accepting edge if A is empty.
- A miss returns data=0, hit=0, valid=1; every accepted lookup yields exactly one response.

Test Plan:
- Reset, then lookup key 0x05 user 1 -> after 2 edges: valid=1, hit=0, data=0, user=1; entry_count=0.
- Update (0x05, 0xDEADBEEF), then lookup 0x05 user 3 -> hit=1, data=0xDEADBEEF, user=3; entry_count=1.
- Update (0x05, 0x1234), then lookup -> data=0x1234; entry_count stays 1; no update_evict.
- Fill 16 distinct keys 0x10..0x1F, then insert 0x20 and 0x21:
  - Each of those two updates gives an update_evict pulse and entry_count=16.
  - Lookups of 0x10 and 0x11 miss; 0x20 and 0x21 hit.
- Hold lookup_value_ready=0 with 3 lookups issued:
  - Only 2 are accepted and the output holds stable.
  - An update to the stalled A key during the stall is reflected when released.
  - The remaining responses come out in order, with correct user tags.
- Update and lookup of key 0x30 in the same cycle -> lookup reports hit=0; a repeat lookup reports hit=1. Assert rst mid-pipeline -> no response emerges and entry_count=0.
